scan_unload_ctrl: RTL and testbench
===================================

Name: scan_unload_ctrl

Overview:
- Scan-test sequencer that runs one unload pass of a single scan chain built from the library's SDFF* cells.
- Drives the chain's SE and a shift clock-enable, which feeds E of a CLKGATETST_* cell.
- Deserializes the chain's scan-out stream into parallel words and hands them to the test-access logic over a valid/ready port.
- Optionally issues one capture cycle after the unload.
- It is the receiving end of the scan path: the chain serializes, this block collects.

Parameters:
- CHAIN_LEN, 64, number of flops in the chain (>=1).
- WORD_W, 8, output word width in bits (>=1).
- Derived localparams: BIT_CNT_W = clog2(CHAIN_LEN+1); WORD_CNT_W = clog2(WORD_W+1).

Ports:
- CK  in  1  clock; chain flops and this block share it.
- RN  in  1  reset, asynchronous, active-low.
- START  in  1  single-cycle request to begin an unload; ignored unless in IDLE.
- CAP_EN  in  1  sampled with START; 1 = issue one capture cycle after the shift.
- ABORT  in  1  terminates any operation.
- SO  in  1  scan-out of the last chain flop.
- SE  out  1  scan-enable to all chain flops.
- SCAN_CE  out  1  chain clock enable, to CLKGATETST E.
- OUT_DATA  out  WORD_W  deserialized word; first-shifted bit at bit 0.
- OUT_VALID  out  1  OUT_DATA holds a word.
- OUT_READY  in  1  consumer accepts the word.
- OUT_LAST  out  1  qualifies the final word of a pass.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset (RN=0, async): state=IDLE. SE, SCAN_CE, OUT_VALID, OUT_LAST, BUSY, DONE = 0. OUT_DATA = 0. All counters = 0, cap flag = 0.
- States: IDLE, SHIFT, CAPTURE, FINISH. State, SE and DONE are registered.
- IDLE:
  - START=1 → SHIFT next cycle.
  - CAP_EN is latched into the cap flag on the same edge.
  - bit_cnt and word_cnt are cleared.
- SHIFT:
  - SE=1, BUSY=1.
  - A shift cycle is any cycle with SE=1 and SCAN_CE=1. On its rising edge:
    - SO is written into shift_reg[word_cnt];
    - word_cnt and bit_cnt increment.
- SCAN_CE in SHIFT is combinational: SCAN_CE = !(completing && OUT_VALID && !OUT_READY).
  - completing = (word_cnt==WORD_W-1) or (bit_cnt==CHAIN_LEN-1).
  - Net effect: the chain stalls only when a word would complete while the holding register is occupied and not being taken.
- Word completion (on a shift cycle with completing=1):
  - OUT_DATA gets the assembled word. Bits above the received count are 0, so a short final word is zero-padded.
  - OUT_VALID is set and word_cnt is reset to 0.
  - OUT_LAST=1 if bit_cnt==CHAIN_LEN-1.
- Output handshake:
  - A transfer occurs when OUT_VALID && OUT_READY.
  - OUT_VALID clears after a transfer unless a new word loads on the same edge.
  - OUT_DATA and OUT_LAST are stable while OUT_VALID=1 and OUT_READY=0.
- Last shift cycle (bit_cnt==CHAIN_LEN-1):
  - next state = CAPTURE if the cap flag is set, else FINISH.
  - SE goes 0 on the following cycle.
- CAPTURE: exactly one cycle with SE=0, SCAN_CE=1, then FINISH.
- FINISH:
  - SCAN_CE=0, BUSY=1.
  - Waits until OUT_VALID=0, i.e. the last word has been accepted.
  - Then DONE pulses for one cycle and state returns to IDLE on the same edge.
- SCAN_CE=0 in IDLE and FINISH.
- Shift count: exactly CHAIN_LEN shift cycles per pass regardless of stalls. Number of words per pass = ceil(CHAIN_LEN/WORD_W).
- ABORT=1 (any state except IDLE):
  - next cycle: state=IDLE; SE, SCAN_CE, OUT_VALID, OUT_LAST = 0; counters cleared; no DONE pulse.
  - ABORT has priority over START and over word completion on the same edge.
- START while BUSY: ignored, with no effect on the counters.
- Reset asserted mid-pass: outputs go to their reset values immediately, with no clock required.

Test Plan:
1. CHAIN_LEN=16, WORD_W=8, CAP_EN=0, OUT_READY=1, SO stream LSB-first 0xA5 then 0x3C.
   - SE high exactly 16 consecutive cycles, starting 1 cycle after START.
   - OUT_DATA=0xA5 with OUT_LAST=0, then OUT_DATA=0x3C with OUT_LAST=1.
   - DONE pulses once; BUSY then falls.
2. Same setup with CAP_EN=1.
   - After the 16th shift, exactly one cycle with SE=0, SCAN_CE=1; then DONE.
   - Total START-to-DONE spacing is one cycle longer than scenario 1.
3. Hold OUT_READY=0 after the first word.
   - SCAN_CE=0 on the cycle the second word would complete; SE stays 1.
   - OUT_DATA holds 0xA5 unchanged.
   - Raising OUT_READY resumes shifting: 16 shift cycles total, second word 0x3C.
4. CHAIN_LEN=10, WORD_W=8, SO all ones.
   - Words 0xFF, then 0x03 with OUT_LAST=1.
   - Exactly 10 shift cycles.
5. ABORT asserted at shift 5.
   - Next cycle: SE=0, SCAN_CE=0, OUT_VALID=0, BUSY=0, no DONE.
   - A new START then runs a clean full pass.
6. RN pulled low asynchronously mid-SHIFT (between clock edges).
   - All outputs 0 immediately.
   - After release, START still required; a pass produces the correct words.

Source files
------------

// File: rtl/scan_unload_ctrl.sv
// Scan unload sequencer: drives SE / shift clock-enable for one chain pass and
// deserializes the chain's scan-out stream into words on a valid/ready port.
module scan_unload_ctrl #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              START,
  input  logic              CAP_EN,
  input  logic              ABORT,
  input  logic              SO,
  output logic              SE,
  output logic              SCAN_CE,
  output logic [WORD_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic              DONE
);

  localparam int BIT_CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WORD_CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_FINISH
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_se;
  logic                  r_done;
  logic                  r_cap;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [WORD_CNT_W-1:0] r_word_cnt;
  logic [WORD_W-1:0]     r_shift;
  logic [WORD_W-1:0]     r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;

  logic                  w_last_bit;
  logic                  w_completing;
  logic                  w_scan_ce;
  logic                  w_shift;
  logic                  w_load;
  logic                  w_xfer;
  logic                  w_drained;
  logic [WORD_W-1:0]     w_word;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_last_bit   = (r_bit_cnt == BIT_CNT_W'(CHAIN_LEN - 1));
    w_completing = (r_word_cnt == WORD_CNT_W'(WORD_W - 1)) || w_last_bit;
    w_xfer       = r_out_valid && OUT_READY;
    // Holding register will be empty after this edge.
    w_drained    = !r_out_valid || OUT_READY;

    w_scan_ce = 1'b0;
    case (r_state)
      S_SHIFT:   w_scan_ce = !(w_completing && r_out_valid && !OUT_READY);
      S_CAPTURE: w_scan_ce = 1'b1;
      default:   w_scan_ce = 1'b0;
    endcase

    w_shift = r_se && w_scan_ce;
    w_load  = w_shift && w_completing;

    // Bits above the current position are already zero, which pads a short final word.
    w_word = r_shift;
    for (int i = 0; i < WORD_W; i++) begin
      if (WORD_CNT_W'(i) == r_word_cnt) w_word[i] = SO;
    end

    w_next_state = r_state;
    if (ABORT) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (START) w_next_state = S_SHIFT;
        S_SHIFT:   if (w_shift && w_last_bit) w_next_state = r_cap ? S_CAPTURE : S_FINISH;
        S_CAPTURE: w_next_state = S_FINISH;
        S_FINISH:  if (w_drained) w_next_state = S_IDLE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state    <= S_IDLE;
      r_se       <= 1'b0;
      r_done     <= 1'b0;
      r_cap      <= 1'b0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_shift    <= '0;
    end else begin
      r_state <= w_next_state;
      r_se    <= (w_next_state == S_SHIFT);
      r_done  <= (r_state == S_FINISH) && w_drained && !ABORT;
      if (ABORT) begin
        r_cap      <= 1'b0;
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_shift    <= '0;
      end else if (r_state == S_IDLE) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_shift    <= '0;
        if (START) r_cap <= CAP_EN;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        if (w_completing) begin
          r_word_cnt <= '0;
          r_shift    <= '0;
        end else begin
          r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
          r_shift    <= w_word;
        end
      end
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (ABORT) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_word;
      r_out_valid <= 1'b1;
      r_out_last  <= w_last_bit;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign SE        = r_se;
  assign SCAN_CE   = w_scan_ce;
  assign OUT_DATA  = r_out_data;
  assign OUT_VALID = r_out_valid;
  assign OUT_LAST  = r_out_last;
  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = r_done;

endmodule

// File: tb/tb_scan_unload_ctrl.sv
// Bench for scan_unload_ctrl: a 16-flop/8-bit instance checked every cycle
// against a word-level model, plus a 10-flop instance with directed checks.
module tb_scan_unload_ctrl;

  localparam int CL  = 16;
  localparam int W   = 8;
  localparam int CLB = 10;
  localparam int NW  = (CL + W - 1) / W;

  logic CK = 1'b0;
  logic RN = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, cap_en = 1'b0, abort = 1'b0;
  logic out_ready = 1'b1;
  logic so_a, so_b;

  logic se_a, ce_a, valid_a, last_a, busy_a, done_a;
  logic [W-1:0] data_a;
  logic se_b, ce_b, valid_b, last_b, busy_b, done_b;
  logic [W-1:0] data_b;

  scan_unload_ctrl #(.CHAIN_LEN(CL), .WORD_W(W)) u_dut_a (
    .CK(CK), .RN(RN), .START(start_a), .CAP_EN(cap_en), .ABORT(abort), .SO(so_a),
    .SE(se_a), .SCAN_CE(ce_a), .OUT_DATA(data_a), .OUT_VALID(valid_a),
    .OUT_READY(out_ready), .OUT_LAST(last_a), .BUSY(busy_a), .DONE(done_a)
  );

  scan_unload_ctrl #(.CHAIN_LEN(CLB), .WORD_W(W)) u_dut_b (
    .CK(CK), .RN(RN), .START(start_b), .CAP_EN(cap_en), .ABORT(abort), .SO(so_b),
    .SE(se_b), .SCAN_CE(ce_b), .OUT_DATA(data_b), .OUT_VALID(valid_b),
    .OUT_READY(out_ready), .OUT_LAST(last_b), .BUSY(busy_b), .DONE(done_b)
  );

  always #5 CK = ~CK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chain A model: its scan-out presents stream bit N after N shift cycles of the pass.
  logic [63:0] stream_a = 64'h0;
  int n_shift   = 0;
  int pass_base = 0;
  always @(posedge CK) if (se_a && ce_a) n_shift <= n_shift + 1;
  assign so_a = stream_a[6'(n_shift - pass_base)];

  // Word-level model and per-cycle compare for instance A.
  logic [W:0]   exp_q[$];
  int           shift_cycles = 0, se_cycles = 0, cap_cycles = 0, done_cnt = 0, obs_n = 0;
  logic [W-1:0] obs_data[8];
  logic         obs_last[8];
  logic         pass_active = 1'b0, prev_hold = 1'b0, prev_last = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(negedge CK) begin : mon
    logic [W:0]   e;
    logic [W-1:0] wv;
    logic         exp_ce;
    if (!RN) begin
      exp_q.delete();
      pass_active  = 1'b0;
      prev_hold    = 1'b0;
      shift_cycles = 0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(valid_a), 32'd1);
        check("hold_data",  32'(data_a), 32'(prev_data));
        check("hold_last",  32'(last_a), 32'(prev_last));
      end
      if (se_a) begin
        exp_ce = !(valid_a && !out_ready &&
                   ((shift_cycles % W) == W - 1 || shift_cycles == CL - 1));
        check("scan_ce", 32'(ce_a), 32'(exp_ce));
      end
      if (!busy_a) check("idle_quiet", 32'({se_a, ce_a}), 32'd0);
      if (valid_a && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(data_a), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 32'(data_a), 32'(e[W-1:0]));
          check("word_last", 32'(last_a), 32'(e[W]));
          if (obs_n < 8) begin
            obs_data[obs_n] = data_a;
            obs_last[obs_n] = last_a;
          end
          obs_n++;
        end
      end
      if (se_a) se_cycles++;
      if (se_a && ce_a) shift_cycles++;
      if (busy_a && !se_a && ce_a) cap_cycles++;
      if (done_a) begin
        done_cnt++;
        check("done_in_pass",  32'(pass_active), 32'd1);
        check("done_shifts",   32'(shift_cycles), 32'(CL));
        check("done_q_empty",  32'(exp_q.size()), 32'd0);
        check("done_valid",    32'(valid_a), 32'd0);
        check("done_busy",     32'(busy_a), 32'd0);
        pass_active = 1'b0;
      end
      if (abort && busy_a) begin
        exp_q.delete();
        pass_active = 1'b0;
      end
      if (start_a && !busy_a && !abort) begin
        shift_cycles = 0; se_cycles = 0; cap_cycles = 0; obs_n = 0;
        pass_base    = n_shift;
        pass_active  = 1'b1;
        exp_q.delete();
        for (int k = 0; k < NW; k++) begin
          wv = '0;
          for (int j = 0; j < W; j++) if (k * W + j < CL) wv[j] = stream_a[k * W + j];
          exp_q.push_back({(k == NW - 1), wv});
        end
      end
      prev_hold = valid_a && !out_ready && !abort;
      prev_data = data_a;
      prev_last = last_a;
    end
  end

  int sb_shifts = 0;
  always @(negedge CK) begin
    if (start_b && !busy_b) sb_shifts = 0;
    else if (se_b && ce_b) sb_shifts++;
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic start_pass_a(input logic cap);
    cap_en  = cap;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    while (!done_a && n < 300) begin
      tick();
      n++;
    end
    if (!done_a) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_words(input string tag, input logic [W-1:0] w0, input logic [W-1:0] w1);
    check({tag, "_nwords"}, 32'(obs_n), 32'd2);
    check({tag, "_w0"},     32'(obs_data[0]), 32'(w0));
    check({tag, "_last0"},  32'(obs_last[0]), 32'd0);
    check({tag, "_w1"},     32'(obs_data[1]), 32'(w1));
    check({tag, "_last1"},  32'(obs_last[1]), 32'd1);
  endtask

  initial begin : stim
    int n, d0, k, nb;
    logic [W-1:0] bw[4];
    logic         bl[4];
    so_b = 1'b1;

    #3;
    check("rst_outputs", 32'({se_a, ce_a, valid_a, last_a, busy_a, done_a}), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    #9 RN = 1'b1;
    tick();

    // Plain pass, always ready.
    stream_a  = 64'h3CA5;
    out_ready = 1'b1;
    start_pass_a(1'b0);
    wait_done_a(n);
    check("s1_latency", 32'(n), 32'd17);
    check("s1_se_cycles", 32'(se_cycles), 32'd16);
    check("s1_cap_cycles", 32'(cap_cycles), 32'd0);
    check_words("s1", 8'hA5, 8'h3C);
    repeat (2) tick();

    // Capture cycle adds exactly one cycle.
    start_pass_a(1'b1);
    wait_done_a(n);
    check("s2_latency", 32'(n), 32'd18);
    check("s2_cap_cycles", 32'(cap_cycles), 32'd1);
    check("s2_se_cycles", 32'(se_cycles), 32'd16);
    check_words("s2", 8'hA5, 8'h3C);
    repeat (2) tick();

    // Consumer back-pressure stalls the chain at the second word.
    out_ready = 1'b0;
    start_pass_a(1'b0);
    repeat (15) tick();
    check("s3_stall_ce", 32'(ce_a), 32'd0);
    check("s3_stall_se", 32'(se_a), 32'd1);
    check("s3_stall_data", 32'(data_a), 32'hA5);
    repeat (3) tick();
    check("s3_still_stalled", 32'({se_a, ce_a}), 32'b10);
    check("s3_held_data", 32'(data_a), 32'hA5);
    out_ready = 1'b1;
    wait_done_a(n);
    check("s3_resume_latency", 32'(n), 32'd2);
    check_words("s3", 8'hA5, 8'h3C);
    repeat (2) tick();

    // Short final word on the 10-flop chain of all ones.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    k = 0; nb = 0;
    while (k < 60 && !done_b) begin
      if (valid_b && out_ready && nb < 4) begin
        bw[nb] = data_b;
        bl[nb] = last_b;
        nb++;
      end
      tick();
      k++;
    end
    check("s4_done", 32'(done_b), 32'd1);
    check("s4_nwords", 32'(nb), 32'd2);
    check("s4_w0", 32'(bw[0]), 32'hFF);
    check("s4_last0", 32'(bl[0]), 32'd0);
    check("s4_w1", 32'(bw[1]), 32'h03);
    check("s4_last1", 32'(bl[1]), 32'd1);
    check("s4_shifts", 32'(sb_shifts), 32'(CLB));
    repeat (2) tick();

    // Abort mid-shift, then a clean pass.
    stream_a = 64'h5A0F;
    start_pass_a(1'b0);
    repeat (4) tick();
    d0    = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s5_abort_outs", 32'({se_a, ce_a, valid_a, busy_a, done_a}), 32'd0);
    repeat (4) tick();
    check("s5_no_done", 32'(done_cnt), 32'(d0));
    start_pass_a(1'b0);
    wait_done_a(n);
    check("s5_latency", 32'(n), 32'd17);
    check_words("s5", 8'h0F, 8'h5A);
    repeat (2) tick();

    // Asynchronous reset mid-shift.
    stream_a = 64'hC381;
    start_pass_a(1'b0);
    repeat (6) tick();
    #2 RN = 1'b0;
    #1;
    check("s6_rst_outs", 32'({se_a, ce_a, valid_a, last_a, busy_a, done_a}), 32'd0);
    check("s6_rst_data", 32'(data_a), 32'd0);
    #10 RN = 1'b1;
    repeat (3) tick();
    check("s6_needs_start", 32'({se_a, busy_a}), 32'd0);
    start_pass_a(1'b0);
    wait_done_a(n);
    check("s6_latency", 32'(n), 32'd17);
    check_words("s6", 8'h81, 8'hC3);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
